// File: rtl/arr4x4_feeder.sv
// Upstream sequencer for the 4x4 systolic array: loads four weight rows, then streams
// diagonally skewed activation vectors followed by a zero drain and a done pulse.
module arr4x4_feeder #(
   parameter int unsigned DW        = 8,
   parameter int unsigned DRAIN_CYC = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            w_valid,
   output logic            w_ready,
   input  logic [4*DW-1:0] w_row,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic            a_last,
   input  logic [4*DW-1:0] a_vec,
   output logic [DW-1:0]   w1_out,
   output logic [DW-1:0]   w2_out,
   output logic [DW-1:0]   w3_out,
   output logic [DW-1:0]   w4_out,
   output logic [DW-1:0]   a1_out,
   output logic [DW-1:0]   a2_out,
   output logic [DW-1:0]   a3_out,
   output logic [DW-1:0]   a4_out,
   output logic            hold,
   output logic            busy,
   output logic            done
);

   localparam int unsigned VW = 4 * DW;
   localparam int unsigned CW = $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      row_cnt_q, row_cnt_d;
   logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
   logic            hold_d;
   logic            done_d;
   logic [VW-1:0]   inj;
   logic            w_acc;
   logic            a_acc;

   // Skew delay stages for lanes 1..3
   logic [DW-1:0]        s2_q;
   logic [1:0][DW-1:0]   s3_q;
   logic [2:0][DW-1:0]   s4_q;

   assign w_acc = w_valid & w_ready;
   assign a_acc = a_valid & a_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_cnt_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Next state; idle cycles in LOAD raise hold so gaps never shift the array
   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      drain_cnt_d = drain_cnt_q;
      hold_d      = hold;
      done_d      = 1'b0;
      inj         = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               row_cnt_d = '0;
            end
         end
         LOAD: begin
            hold_d = ~w_acc;
            if (w_acc) begin
               row_cnt_d = row_cnt_q + 2'd1;
               if (row_cnt_q == 2'd3) begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            hold_d = 1'b1;
            if (a_acc) begin
               inj = a_vec;
               if (a_last) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            hold_d = 1'b1;
            if (drain_cnt_q == CW'(DRAIN_CYC - 1)) begin
               done_d      = 1'b1;
               state_d     = IDLE;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered handshakes, status and weight lanes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ready <= 1'b0;
         a_ready <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hold    <= 1'b0;
         w1_out  <= '0;
         w2_out  <= '0;
         w3_out  <= '0;
         w4_out  <= '0;
      end else begin
         w_ready <= (state_d == LOAD);
         a_ready <= (state_d == STREAM);
         busy    <= (state_d != IDLE);
         done    <= done_d;
         hold    <= hold_d;
         if (w_acc) begin
            w1_out <= w_row[0*DW +: DW];
            w2_out <= w_row[1*DW +: DW];
            w3_out <= w_row[2*DW +: DW];
            w4_out <= w_row[3*DW +: DW];
         end
      end
   end

   // Diagonal skew: lane k sees k extra register stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_out <= '0;
         a2_out <= '0;
         a3_out <= '0;
         a4_out <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         s4_q   <= '0;
      end else begin
         a1_out  <= inj[0*DW +: DW];
         s2_q    <= inj[1*DW +: DW];
         a2_out  <= s2_q;
         s3_q[0] <= inj[2*DW +: DW];
         s3_q[1] <= s3_q[0];
         a3_out  <= s3_q[1];
         s4_q[0] <= inj[3*DW +: DW];
         s4_q[1] <= s4_q[0];
         s4_q[2] <= s4_q[1];
         a4_out  <= s4_q[2];
      end
   end

endmodule

// File: tb/tb_arr4x4_feeder.sv
// Directed self-checking bench for arr4x4_feeder: load with and without gaps,
// skewed streaming with bubbles, drain/done timing, stray inputs and mid-job reset.
module tb_arr4x4_feeder;

   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          w_valid;
   logic          w_ready;
   logic [31:0]   w_row;
   logic          a_valid;
   logic          a_ready;
   logic          a_last;
   logic [31:0]   a_vec;
   logic [DW-1:0] w1_out, w2_out, w3_out, w4_out;
   logic [DW-1:0] a1_out, a2_out, a3_out, a4_out;
   logic          hold;
   logic          busy;
   logic          done;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] rows [4];
   logic [31:0] av   [12];
   logic [31:0] aexp [12];
   logic        avld [12];
   logic        alast[12];

   arr4x4_feeder #(.DW(DW), .DRAIN_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_vec(a_vec),
      .w1_out(w1_out), .w2_out(w2_out), .w3_out(w3_out), .w4_out(w4_out),
      .a1_out(a1_out), .a2_out(a2_out), .a3_out(a3_out), .a4_out(a4_out),
      .hold(hold), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                      input logic [7:0] l2, input logic [7:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [31:0] w_obs();
      return {w4_out, w3_out, w2_out, w1_out};
   endfunction

   function automatic logic [31:0] a_obs();
      return {a4_out, a3_out, a2_out, a1_out};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_job(input bit gap);
      start = 1'b1;
      step();
      start = 1'b0;
      check("ld_wready", 32'(w_ready), 32'd1);
      for (int r = 0; r < 4; r++) begin
         w_valid = 1'b1;
         w_row   = rows[r];
         step();
         check("ld_w", w_obs(), rows[r]);
         check("ld_hold0", 32'(hold), 32'd0);
         if (gap && r == 1) begin
            w_valid = 1'b0;
            w_row   = 32'hdeadbeef;
            start   = 1'b1;
            for (int g = 0; g < 2; g++) begin
               step();
               check("gap_hold", 32'(hold), 32'd1);
               check("gap_w", w_obs(), rows[1]);
               check("gap_wready", 32'(w_ready), 32'd1);
            end
            start = 1'b0;
         end
      end
      w_valid = 1'b0;
      check("ld_aready", 32'(a_ready), 32'd1);
      check("ld_wready_off", 32'(w_ready), 32'd0);
      check("ld_busy", 32'(busy), 32'd1);
      // Stray start / w_valid in STREAM must be ignored
      start   = 1'b1;
      w_valid = 1'b1;
      w_row   = 32'h5a5a5a5a;
      step();
      start   = 1'b0;
      w_valid = 1'b0;
      check("st_hold", 32'(hold), 32'd1);
      check("st_w", w_obs(), rows[3]);
      check("st_aready", 32'(a_ready), 32'd1);
      check("st_wready", 32'(w_ready), 32'd0);
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 12; i++) begin
         av[i]    = '0;
         aexp[i]  = '0;
         avld[i]  = 1'b0;
         alast[i] = 1'b0;
      end
   endtask

   task automatic set_scn_plain();
      clear_tables();
      av[0] = pk(8, 7, 6, 5); avld[0] = 1'b1;
      av[1] = pk(7, 6, 5, 4); avld[1] = 1'b1;
      av[2] = pk(6, 5, 4, 3); avld[2] = 1'b1; alast[2] = 1'b1;
      aexp[0] = pk(8, 0, 0, 0);
      aexp[1] = pk(7, 7, 0, 0);
      aexp[2] = pk(6, 6, 6, 0);
      aexp[3] = pk(0, 5, 5, 5);
      aexp[4] = pk(0, 0, 4, 4);
      aexp[5] = pk(0, 0, 0, 3);
   endtask

   task automatic set_scn_bubble();
      clear_tables();
      av[0] = pk(1, 2, 3, 4);     avld[0] = 1'b1;
      av[1] = pk(99, 99, 99, 99); alast[1] = 1'b1;
      av[2] = pk(5, 6, 7, 8);     avld[2] = 1'b1; alast[2] = 1'b1;
      aexp[0] = pk(1, 0, 0, 0);
      aexp[1] = pk(0, 2, 0, 0);
      aexp[2] = pk(5, 0, 3, 0);
      aexp[3] = pk(0, 6, 0, 4);
      aexp[4] = pk(0, 0, 7, 0);
      aexp[5] = pk(0, 0, 0, 8);
   endtask

   // Last vector accepted at index 2, so done lands 8 edges later at index 10
   task automatic stream_job();
      for (int i = 0; i < 12; i++) begin
         a_valid = avld[i];
         a_vec   = av[i];
         a_last  = alast[i];
         step();
         check($sformatf("a_lanes[%0d]", i), a_obs(), aexp[i]);
         check($sformatf("done[%0d]", i), 32'(done), 32'(i == 10));
         check($sformatf("busy[%0d]", i), 32'(busy), 32'(i < 10));
      end
      a_valid = 1'b0;
      a_last  = 1'b0;
      a_vec   = '0;
      check("post_w", w_obs(), rows[3]);
      check("post_hold", 32'(hold), 32'd1);
      check("post_aready", 32'(a_ready), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      w_valid = 1'b0;
      w_row   = '0;
      a_valid = 1'b0;
      a_last  = 1'b0;
      a_vec   = '0;
      rows[0] = pk(4, 3, 2, 1);
      rows[1] = pk(8, 7, 6, 5);
      rows[2] = pk(4, 3, 2, 1);
      rows[3] = pk(8, 7, 6, 5);

      #12;
      check("rst_a", a_obs(), 32'd0);
      check("rst_w", w_obs(), 32'd0);
      check("rst_hold", 32'(hold), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wready", 32'(w_ready), 32'd0);
      check("rst_aready", 32'(a_ready), 32'd0);
      rst_n = 1'b1;
      step();

      // Back-to-back load, plain stream
      load_job(1'b0);
      set_scn_plain();
      stream_job();

      // Load with a two-cycle gap, stream with a bubble
      load_job(1'b1);
      set_scn_bubble();
      stream_job();

      // Reset in the middle of a stream
      load_job(1'b0);
      a_valid = 1'b1;
      a_vec   = pk(9, 9, 9, 9);
      a_last  = 1'b0;
      step();
      a_valid = 1'b0;
      check("pre_rst_a", a_obs(), pk(9, 0, 0, 0));
      rst_n = 1'b0;
      #2;
      check("mid_rst_a", a_obs(), 32'd0);
      check("mid_rst_w", w_obs(), 32'd0);
      check("mid_rst_hold", 32'(hold), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_wready", 32'(w_ready), 32'd0);
      check("post_rst_a", a_obs(), 32'd0);

      // Full job after reset
      load_job(1'b0);
      set_scn_plain();
      stream_job();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
